// File: rtl/down_counter.sv
// down_counter: loadable down-counter with clamped load, optional wraparound
// reload, abort input and a registered one-cycle terminal-count pulse.
module down_counter #(
  parameter int LOWER      = 0,
  parameter int UPPER      = 255,
  parameter int WRAPAROUND = 0,
  localparam int WIDTH     = $clog2(UPPER + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             stop_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  input  logic [WIDTH-1:0] ld_value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             busy_o,
  output logic             tc_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] LOWER_V = WIDTH'(LOWER);
  localparam logic [WIDTH-1:0] UPPER_V = WIDTH'(UPPER);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  // NOTE: declaration initialisers give the same power-up state as reset, so
  // the registers are valid before the first rst pulse.
  state_t           state_q  = IDLE;
  logic [WIDTH-1:0] count_q  = UPPER_V;
  logic [WIDTH-1:0] reload_q = UPPER_V;
  logic             tc_q     = 1'b0;

  state_t           state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_d;
  logic             tc_d;
  logic [WIDTH-1:0] ld_clamped;

  // Limit the requested start value to the legal count range.
  always_comb begin
    if (ld_value_i <= LOWER_V) begin
      ld_clamped = LOWER_V;
    end else if (ld_value_i >= UPPER_V) begin
      ld_clamped = UPPER_V;
    end else begin
      ld_clamped = ld_value_i;
    end
  end

  // State, count, reload and tc registers; reset overrides every other input.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the values
    // that were present before this edge.
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= UPPER_V;
      reload_q <= UPPER_V;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: load in IDLE; abort, decrement or terminal event in RUN.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned and infers a latch.
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_valid_i) begin
          count_d  = ld_clamped;
          reload_d = ld_clamped;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          // Abort wins over both decrement and terminal event.
          state_d = IDLE;
        end else if (ena_i) begin
          if (count_q <= LOWER_V) begin
            tc_d = 1'b1;
            if (WRAPAROUND != 0) begin
              count_d = reload_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - ONE_V;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy_o     = (state_q == RUN);
    ld_ready_o = (state_q == IDLE);
  end

  assign value_o = count_q;
  assign tc_o    = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: three down_counter instances (default range, clamped
// range 5..200, wraparound) driven by directed and random stimulus and
// compared every cycle against an integer reference model.
module tb_down_counter;

  localparam int N = 3;
  localparam int LO_P [N] = '{0, 5, 0};
  localparam int UP_P [N] = '{255, 200, 255};
  localparam int WR_P [N] = '{0, 0, 1};

  typedef struct {
    int cnt;
    int rel;
    bit run;
    bit tc;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst   [N];
  logic       ena   [N];
  logic       stop  [N];
  logic       ldv   [N];
  logic [7:0] ldval [N];
  logic [7:0] val   [N];
  logic       busy  [N];
  logic       rdy   [N];
  logic       tc    [N];

  mdl_t mdl [N];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  down_counter #(.LOWER(0), .UPPER(255), .WRAPAROUND(0)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .ena_i(ena[0]), .stop_i(stop[0]),
    .ld_valid_i(ldv[0]), .ld_ready_o(rdy[0]), .ld_value_i(ldval[0]),
    .value_o(val[0]), .busy_o(busy[0]), .tc_o(tc[0]));

  down_counter #(.LOWER(5), .UPPER(200), .WRAPAROUND(0)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .ena_i(ena[1]), .stop_i(stop[1]),
    .ld_valid_i(ldv[1]), .ld_ready_o(rdy[1]), .ld_value_i(ldval[1]),
    .value_o(val[1]), .busy_o(busy[1]), .tc_o(tc[1]));

  down_counter #(.LOWER(0), .UPPER(255), .WRAPAROUND(1)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .ena_i(ena[2]), .stop_i(stop[2]),
    .ld_valid_i(ldv[2]), .ld_ready_o(rdy[2]), .ld_value_i(ldval[2]),
    .value_o(val[2]), .busy_o(busy[2]), .tc_o(tc[2]));

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one edge, written from the counter's rules.
  function automatic mdl_t step(input mdl_t m, input int lo, input int up,
                                input int wrap, input bit r, input bit e,
                                input bit s, input bit lv, input int lval);
    mdl_t n;
    int   c;
    n    = m;
    n.tc = 1'b0;
    if (r) begin
      n.cnt = up;
      n.rel = up;
      n.run = 1'b0;
    end else if (!m.run) begin
      if (lv) begin
        c = (lval > up) ? up : ((lval < lo) ? lo : lval);
        n.cnt = c;
        n.rel = c;
        n.run = 1'b1;
      end
    end else if (s) begin
      n.run = 1'b0;
    end else if (e) begin
      if (m.cnt == lo) begin
        n.tc = 1'b1;
        if (wrap != 0) n.cnt = m.rel;
        else           n.run = 1'b0;
      end else begin
        n.cnt = m.cnt - 1;
      end
    end
    return n;
  endfunction

  task automatic drive(input int i, input bit r, input bit e, input bit s,
                       input bit lv, input int lval);
    rst[i]   = r;
    ena[i]   = e;
    stop[i]  = s;
    ldv[i]   = lv;
    ldval[i] = 8'(lval);
  endtask

  // One clock edge: advance the model with the inputs held across the edge,
  // then compare all outputs of all instances shortly after it.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mdl[i] = step(mdl[i], LO_P[i], UP_P[i], WR_P[i], rst[i], ena[i],
                    stop[i], ldv[i], int'(ldval[i]));
      check($sformatf("u%0d.value", i), int'(val[i]), mdl[i].cnt);
      check($sformatf("u%0d.busy", i), int'(busy[i]), int'(mdl[i].run));
      check($sformatf("u%0d.ld_ready", i), int'(rdy[i]), int'(!mdl[i].run));
      check($sformatf("u%0d.tc", i), int'(tc[i]), int'(mdl[i].tc));
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int exp_wrap [7];
    for (int i = 0; i < N; i++) begin
      mdl[i] = '{cnt: UP_P[i], rel: UP_P[i], run: 1'b0, tc: 1'b0};
      drive(i, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    end

    // Reset pulse.
    tick();
    check("rst.value", int'(val[0]), 255);
    check("rst.busy", int'(busy[0]), 0);
    check("rst.ld_ready", int'(rdy[0]), 1);
    check("rst.tc", int'(tc[0]), 0);
    idle_all();
    tick();

    // Basic countdown from 3.
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    tick();
    check("cd.load", int'(val[0]), 3);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 2; k >= 0; k--) begin
      tick();
      check("cd.value", int'(val[0]), k);
      check("cd.tc_low", int'(tc[0]), 0);
    end
    tick();
    check("cd.tc", int'(tc[0]), 1);
    check("cd.busy", int'(busy[0]), 0);
    check("cd.hold", int'(val[0]), 0);
    check("cd.ld_ready", int'(rdy[0]), 1);
    tick();
    check("cd.tc_once", int'(tc[0]), 0);
    idle_all();

    // Clamp and load hold-off on the 5..200 instance.
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 250);
    tick();
    check("clamp.hi", int'(val[1]), 200);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
    tick();
    check("holdoff", int'(val[1]), 200);
    drive(1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    tick();
    check("clamp.lo", int'(val[1]), 5);
    drive(1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    tick();
    check("clamp.lo_tc", int'(tc[1]), 1);
    idle_all();

    // Wraparound: load 2 then 6 more enabled cycles.
    exp_wrap = '{2, 1, 0, 2, 1, 0, 2};
    drive(2, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    tick();
    check("wrap.v0", int'(val[2]), exp_wrap[0]);
    drive(2, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 1; k < 7; k++) begin
      tick();
      check("wrap.value", int'(val[2]), exp_wrap[k]);
      check("wrap.tc", int'(tc[2]), (k == 3 || k == 6) ? 1 : 0);
      check("wrap.busy", int'(busy[2]), 1);
    end
    drive(2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    tick();
    idle_all();

    // Gated enable after loading 4.
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(0, 1'b0, (k % 2) == 0, 1'b0, 1'b0, 0);
      tick();
    end
    idle_all();

    // Stop coincident with the terminal event.
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    tick();
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    tick();
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    tick();
    check("stop.busy", int'(busy[0]), 0);
    check("stop.value", int'(val[0]), 0);
    check("stop.tc", int'(tc[0]), 0);

    // Reset mid-RUN at value 7, then reset on a terminal event.
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 9);
    tick();
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    tick();
    tick();
    check("rstrun.pre", int'(val[0]), 7);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    tick();
    check("rstrun.value", int'(val[0]), 255);
    check("rstrun.busy", int'(busy[0]), 0);
    check("rstrun.tc", int'(tc[0]), 0);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    tick();
    check("rsttc.tc", int'(tc[0]), 0);
    idle_all();
    tick();

    // Random traffic on all instances.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        drive(i, ($urandom_range(63) == 0), ($urandom_range(3) != 0),
              ($urandom_range(15) == 0), ($urandom_range(3) == 0),
              int'($urandom_range(255)));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
